// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared UART constants and receiver state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int unsigned CLK_HZ               = 12_000_000;
  localparam int unsigned BAUD                 = 115_200;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : 1-bit two-flop synchronizer, resets to 1 (idle-high lines)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ----------------------------------------------------------------------------
// uart_rx_byte : 8N1 UART receiver with valid/ready byte output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned           CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rxs;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             bit_end;
  logic             byte_done;
  logic             stop_bad;

  sync_2ff u_sync_rx (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (uart_rx),
    .q_o    (rxs)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A high line at mid start bit was only a glitch.
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : BREAK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign byte_done = (state_q == STOP) && bit_end && rxs;
  assign stop_bad  = (state_q == STOP) && bit_end && !rxs;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (byte_done) begin
      // A same-cycle handshake frees the slot for the new byte.
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != IDLE);
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule : uart_rx_byte

`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_byte : directed self-checking bench for uart_rx_byte
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_byte;

  localparam int CPB  = 104;
  localparam int HALF = 52;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rx   = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         ovr_cnt   = 0;
  int         busy_cnt  = 0;
  int         acc_cnt   = 0;
  int         rise_cyc  = 0;
  logic [7:0] rise_data = 8'h00;
  logic [7:0] acc_data  = 8'h00;
  logic       valid_prev = 1'b0;

  uart_rx_byte #(
    .CLKS_PER_BIT (CPB),
    .HALF_BIT     (HALF)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Inputs change #1 after posedge, so negedge values hold into the next edge.
  always @(negedge sys_clk) begin
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (framing_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_busy) busy_cnt <= busy_cnt + 1;
    if (rx_valid && rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_data <= rx_data;
    end
    if (rx_valid && !valid_prev) begin
      rise_cyc  <= cyc;
      rise_data <= rx_data;
    end
    valid_prev <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Called #1 after a posedge; pulse_at > 0 raises rx_ready for the single
  // posedge that lies pulse_at cycles after the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int pulse_at, output int s);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    s  = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      uart_rx = fr[c / CPB];
      if (pulse_at > 0) rx_ready = (c == pulse_at - 1);
      @(posedge sys_clk);
      #1;
    end
    uart_rx = stop_bit;
  endtask

  int s, b_valid, b_ferr, b_ovr, b_busy, b_acc;

  task automatic snap();
    b_valid = valid_cnt;
    b_ferr  = ferr_cnt;
    b_ovr   = ovr_cnt;
    b_busy  = busy_cnt;
    b_acc   = acc_cnt;
  endtask

  initial begin
    // Reset state
    wait_cycles(4);
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", framing_err, 0);
    check("rst_ovr", overrun, 0);
    sys_rst_n = 1'b1;
    wait_cycles(10);

    // 0xA5 with ready held high
    rx_ready = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1, 0, s);
    check("a5_latency", rise_cyc - s, LAT);
    check("a5_data", rise_data, 8'hA5);
    check("a5_valid_cycles", valid_cnt - b_valid, 1);
    check("a5_ferr", ferr_cnt - b_ferr, 0);
    check("a5_ovr", ovr_cnt - b_ovr, 0);
    check("a5_valid_after", rx_valid, 0);

    // 30-cycle glitch
    wait_cycles(20);
    snap();
    uart_rx = 1'b0;
    wait_cycles(30);
    uart_rx = 1'b1;
    wait_cycles(100);
    check("glitch_busy_cycles", busy_cnt - b_busy, HALF);
    check("glitch_valid", valid_cnt - b_valid, 0);
    check("glitch_ferr", ferr_cnt - b_ferr, 0);
    check("glitch_ovr", ovr_cnt - b_ovr, 0);

    // 0x3C with low stop bit, line held low, then recovery with 0x81
    snap();
    send_frame(8'h3C, 1'b0, 0, s);
    wait_cycles(500);
    check("brk_busy_held", rx_busy, 1);
    uart_rx = 1'b1;
    wait_cycles(20);
    check("brk_ferr", ferr_cnt - b_ferr, 1);
    check("brk_valid", valid_cnt - b_valid, 0);
    check("brk_idle", rx_busy, 0);
    snap();
    send_frame(8'h81, 1'b1, 0, s);
    check("x81_data", rise_data, 8'h81);
    check("x81_valid_cycles", valid_cnt - b_valid, 1);
    check("x81_ferr", ferr_cnt - b_ferr, 0);

    // Overrun: 0x11 then 0x22 back-to-back with ready low
    rx_ready = 1'b0;
    wait_cycles(10);
    snap();
    send_frame(8'h11, 1'b1, 0, s);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_first_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, 0, s);
    check("ovr_pulses", ovr_cnt - b_ovr, 1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    check("ovr_consumed_valid", rx_valid, 0);
    check("ovr_consumed_data", rx_data, 8'h11);
    check("ovr_acc_data", acc_data, 8'h11);
    wait_cycles(10);

    // Same-cycle consume and load: 0x22 pending, 0x33 arriving
    snap();
    send_frame(8'h22, 1'b1, 0, s);
    check("sim_first_data", rx_data, 8'h22);
    send_frame(8'h33, 1'b1, LAT, s);
    check("sim_ovr", ovr_cnt - b_ovr, 0);
    check("sim_valid", rx_valid, 1);
    check("sim_data", rx_data, 8'h33);
    check("sim_acc_cnt", acc_cnt - b_acc, 1);
    check("sim_acc_data", acc_data, 8'h22);
    rx_ready = 1'b1;
    wait_cycles(1);
    check("sim_drain_valid", rx_valid, 0);
    wait_cycles(10);

    // Reset during data bit 4 of 0xFF, then 0x5A
    uart_rx = 1'b0;
    wait_cycles(CPB);
    uart_rx = 1'b1;
    wait_cycles(4 * CPB + CPB / 2);
    check("mid_busy", rx_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 8'h00);
    check("mid_rst_ferr", framing_err, 0);
    check("mid_rst_ovr", overrun, 0);
    wait_cycles(5);
    sys_rst_n = 1'b1;
    wait_cycles(6 * CPB);
    snap();
    send_frame(8'h5A, 1'b1, 0, s);
    check("x5a_data", rise_data, 8'h5A);
    check("x5a_latency", rise_cyc - s, LAT);
    check("x5a_valid_cycles", valid_cnt - b_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_byte

`default_nettype wire
